// File: rtl/vga_scan_controller.sv
// VGA raster scan: free-running h/v counters, sync generation and colour gating aligned to an RGB_LATENCY-deep pixel source.
// Optional build macro VGA_SCAN_TEST_PATTERN_EN replaces RGBIn with eight vertical colour bars.
module vga_scan_controller #(
    parameter int RGB_WIDTH   = 8,
    parameter int RGB_LATENCY = 1,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pxl_en,
    input  logic [RGB_WIDTH-1:0] RGBIn,
    output logic [10:0]          pixelX,
    output logic [10:0]          pixelY,
    output logic                 startOfFrame,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blankN,
    output logic [RGB_WIDTH-1:0] RGBOut
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

    logic [10:0] hCount, vCount;
    sync_t       raw, tail;
    sync_t       pipe [RGB_LATENCY];
    logic [RGB_WIDTH-1:0] colour;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCount <= '0;
            vCount <= '0;
        end else if (pxl_en) begin
            if (hCount == H_LAST) begin
                hCount <= '0;
                vCount <= (vCount == V_LAST) ? '0 : vCount + 11'd1;
            end else begin
                hCount <= hCount + 11'd1;
            end
        end
    end

    assign pixelX       = hCount;
    assign pixelY       = vCount;
    assign startOfFrame = pxl_en && (hCount == '0) && (vCount == '0);

    assign raw.hs  = !((hCount >= HS_START) && (hCount <= HS_END));
    assign raw.vs  = !((vCount >= VS_START) && (vCount <= VS_END));
    assign raw.act = (hCount < H_ACT) && (vCount < V_ACT);

    // Sync/active ride alongside the external pixel pipeline so they meet RGBIn in step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RGB_LATENCY; i++) pipe[i] <= SYNC_IDLE;
        end else if (pxl_en) begin
            pipe[0] <= raw;
            for (int i = 1; i < RGB_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[RGB_LATENCY-1];

`ifdef VGA_SCAN_TEST_PATTERN_EN
    logic [10:0] hpipe [RGB_LATENCY];
    logic [10:0] vpipe [RGB_LATENCY];
    logic [3:0]  bar;
    logic        pat_bit;
    logic        unused_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RGB_LATENCY; i++) begin
                hpipe[i] <= '0;
                vpipe[i] <= '0;
            end
        end else if (pxl_en) begin
            hpipe[0] <= hCount;
            vpipe[0] <= vCount;
            for (int i = 1; i < RGB_LATENCY; i++) begin
                hpipe[i] <= hpipe[i-1];
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // Odd bars are inverted in the upper half of the screen.
    assign bar        = 4'(hpipe[RGB_LATENCY-1] / 11'd80);
    assign pat_bit    = bar[0] ^ (bar[0] & (vpipe[RGB_LATENCY-1] < 11'd240));
    assign colour     = {RGB_WIDTH{pat_bit}};
    assign unused_rgb = ^RGBIn;
`else
    assign colour = RGBIn;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            blankN <= 1'b0;
            RGBOut <= '0;
        end else if (pxl_en) begin
            hsync  <= tail.hs;
            vsync  <= tail.vs;
            blankN <= tail.act;
            RGBOut <= tail.act ? colour : '0;
        end
    end
endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller; vertical timing shrunk so full frames fit a short run.
module tb_vga_scan_controller;
    localparam int L  = 1;
    localparam int W  = 8;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 12,  VF = 2,  VS = 2,  VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic         hs;
        logic         vs;
        logic         blank;
        logic [W-1:0] rgb;
    } exp_t;

    localparam exp_t IDLE_E = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, rgb: '0};

    logic         clk = 1'b0;
    logic         reset;
    logic         pxl_en;
    logic [W-1:0] rgb_in;
    logic [10:0]  pixelX, pixelY;
    logic         startOfFrame, hsync, vsync, blankN;
    logic [W-1:0] RGBOut;

    exp_t q[$];
    exp_t last;
    int   hm, vm;
    int   n_chk = 0, n_err = 0;
    int   vs_low;
    logic prev_hs;

    vga_scan_controller #(
        .RGB_WIDTH(W), .RGB_LATENCY(L),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .pxl_en(pxl_en), .RGBIn(rgb_in),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .hsync(hsync), .vsync(vsync), .blankN(blankN), .RGBOut(RGBOut)
    );

    always #5 clk = ~clk;

    // Object-mux stand-in: colour = pixelX[7:0], one enabled tick late.
    always @(posedge clk) if (pxl_en) rgb_in <= pixelX[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (model h=%0d v=%0d)", tag, obs, exp, hm, vm);
        end
    endtask

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        e.hs    = !(h >= HA + HF && h < HA + HF + HS);
        e.vs    = !(v >= VA + VF && v < VA + VF + VS);
        e.blank = (h < HA) && (v < VA);
        e.rgb   = e.blank ? h[7:0] : '0;
        return e;
    endfunction

    task automatic model_reset();
        hm = 0; vm = 0;
        q.delete();
        for (int i = 0; i < L; i++) q.push_back(IDLE_E);
        last    = IDLE_E;
        vs_low  = 0;
        prev_hs = 1'b1;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic en);
        pxl_en = en;
        #1;
        chk("pixelX", pixelX, hm);
        chk("pixelY", pixelY, vm);
        chk("sof", startOfFrame, en && hm == 0 && vm == 0);
        if (en) begin
            q.push_back(model(hm, vm));
            last = q.pop_front();
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm = (vm == VT - 1) ? 0 : vm + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("hsync", hsync, last.hs);
        chk("vsync", vsync, last.vs);
        chk("blankN", blankN, last.blank);
        chk("RGBOut", RGBOut, last.rgb);
        if (en) begin
            if (prev_hs && !hsync) chk("hs_fall_x", pixelX, HA + HF + 2);
            if (!prev_hs && hsync) chk("hs_rise_x", pixelX, HA + HF + HS + 2);
            prev_hs = hsync;
            if (pixelX == 7 && pixelY < VA) chk("rgb_px5", RGBOut, 5);
            if (!vsync) vs_low++;
            else if (vs_low > 0) begin
                chk("vsync_len", vs_low, VS * HT);
                vs_low = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_at(input int h, input int v);
        for (int i = 0; i < 2 * HT * VT && !(hm == h && vm == v); i++) step(1'b1);
        chk("seek_x", pixelX, h);
        chk("seek_y", pixelY, v);
        #2 reset = 1'b1;
        #1;
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_blankN", blankN, 0);
        chk("rst_rgb", RGBOut, 0);
        chk("rst_pixelX", pixelX, 0);
        chk("rst_pixelY", pixelY, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (HT + 20) step(1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        pxl_en = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("hold_hsync", hsync, 1);
            chk("hold_blankN", blankN, 0);
            chk("hold_rgb", RGBOut, 0);
            chk("hold_pixelX", pixelX, 0);
        end
        reset = 1'b0;
        // Full frame plus part of the next: covers line wrap, frame wrap and vsync width.
        repeat (HT * VT + 2 * HT) step(1'b1);
        // Alternating pixel tick: one full line of enabled ticks.
        repeat (HT) begin
            step(1'b1);
            step(1'b0);
        end
        // Reset during hsync+vsync, then during the active area.
        reset_at(700, VA + VF);
        reset_at(300, 5);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 SHALL have parameter RGB_WIDTH, default 8, the pixel colour width.
REQ-002 SHALL have parameter RGB_LATENCY, default 1, the pixel-tick delay from pixelX/pixelY to the matching RGBIn.
REQ-003 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (line/frame timing in pixels/lines).
REQ-004 SHALL have port: clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: pxl_en  in  1  pixel tick; all state advances only when high.
REQ-007 SHALL have port: RGBIn  in  RGB_WIDTH  colour from the object mux for the coordinates issued RGB_LATENCY ticks earlier.
REQ-008 SHALL have port: pixelX  out  11  current horizontal count.
REQ-009 SHALL have port: pixelY  out  11  current vertical count.
REQ-010 SHALL have port: startOfFrame  out  1  one-tick frame-start pulse.
REQ-011 SHALL have port: hsync  out  1  horizontal sync, active-low.
REQ-012 SHALL have port: vsync  out  1  vertical sync, active-low.
REQ-013 SHALL have port: blankN  out  1  high while the displayed pixel is in the active area.
REQ-014 SHALL have port: RGBOut  out  RGB_WIDTH  displayed colour.

Function
REQ-015 SHALL keep hCount in 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and vCount in 0..V_TOTAL-1 (525), both advancing only on pxl_en.
REQ-016 SHALL, on pxl_en, increment hCount; when hCount = H_TOTAL-1, wrap it to 0 and increment vCount; when vCount = V_TOTAL-1 at that point, wrap vCount to 0.
REQ-017 SHALL drive pixelX = hCount and pixelY = vCount directly from registers, with no added delay.
REQ-018 SHALL assert startOfFrame only when hCount = 0, vCount = 0 and pxl_en = 1.
REQ-019 SHALL compute raw sync signals as: hs_raw low for hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]; vs_raw low for vCount in [490,491]; act_raw = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
REQ-020 SHALL pass {hs_raw, vs_raw, act_raw} through an RGB_LATENCY-stage shift line, shifting only on pxl_en.
REQ-021 SHALL register the outputs on pxl_en: hsync, vsync and blankN take the delayed values; RGBOut = RGBIn when delayed act is high, else 0.
REQ-022 SHALL make total latency from counter value to hsync/vsync/blankN/RGBOut exactly RGB_LATENCY+1 pxl_en ticks.
REQ-023 SHALL hold all registers (counters, shift line, outputs) when pxl_en = 0.
REQ-024 SHALL never present RGBOut non-zero while blankN = 0.

Reset
REQ-025 SHALL, while reset is high, asynchronously force: hCount = vCount = 0; shift line to hs = 1, vs = 1, act = 0; hsync = 1, vsync = 1, blankN = 0, RGBOut = 0.
REQ-026 SHALL, on reset assertion mid-frame, discard the frame; after release the first pxl_en tick observes counters at (0,0) and startOfFrame = 1.

Configuration
REQ-027 SHALL, with macro VGA_SCAN_TEST_PATTERN_EN defined, ignore RGBIn and output 8 vertical colour bars, each 80 pixels wide; bar k (k = delayed hCount/80) has all bits of RGBOut equal to bit k mod 2, XOR-inverted on odd-numbered bars above line 240.
REQ-028 SHALL, without VGA_SCAN_TEST_PATTERN_EN, use RGBIn per REQ-021 and include no pattern logic.
REQ-029 SHALL keep ports and timing identical in both configurations.

Verification
REQ-030 SHALL cover: reset held, then released with pxl_en = 1 constantly -> pixelX 0,1,2…; hsync = 1, blankN = 0, RGBOut = 0 during reset.
REQ-031 SHALL cover: run to hCount = 799, vCount = 5 -> next tick pixelX = 0, pixelY = 6; at (799,524) -> next tick (0,0) with startOfFrame = 1.
REQ-032 SHALL cover: pxl_en = 1, RGB_LATENCY = 1 -> hsync falls exactly 2 ticks after pixelX = 656 and rises 2 ticks after pixelX = 752; vsync low for exactly 2 lines (1600 ticks).
REQ-033 SHALL cover: RGBIn = pixelX[7:0] delayed by 1 tick -> RGBOut = 8'h05 two ticks after pixelX = 5; RGBOut = 0 whenever pixelX ≥ 640 at issue.
REQ-034 SHALL cover: pxl_en toggling 1/0 -> all outputs change only after pxl_en = 1 ticks, with one line = 800 enabled ticks.
REQ-035 SHALL cover: reset pulse at (300,200) -> immediate outputs hsync = vsync = 1, RGBOut = 0; after release the first tick gives startOfFrame = 1.
